// File: rtl/dm_rmw_ctrl.sv
// CPU-to-memory access controller. It turns half-word and byte stores into a read-modify-write
// sequence on a word-only memory port that has no byte enables.
module dm_rmw_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        We,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic [1:0]  Size,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] RData,
    output logic        Mem_En,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    input  logic [31:0] Mem_RData,
    input  logic        Mem_Ready
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, RESP} state_t;

    state_t      state_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  size_reg;
    logic [31:0] merge_reg;
    logic [31:0] merged;

    // Each byte lane either takes store data or passes the read word through.
    // A half-word store always occupies an aligned lane pair selected by Addr[1] only.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       sel;
            logic [7:0] src;
            assign sel = (size_reg == 2'b10) ? (addr_reg[1:0] == LANE)
                                             : ((size_reg == 2'b01) && (addr_reg[1] == LANE[1]));
            assign src = (size_reg == 2'b10) ? wdata_reg[7:0] : wdata_reg[8*(gi%2) +: 8];
            assign merged[8*gi +: 8] = sel ? src : Mem_RData[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            size_reg  <= '0;
            merge_reg <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            RData     <= '0;
            Mem_En    <= 1'b0;
            Mem_We    <= 1'b0;
            Mem_Addr  <= '0;
            Mem_WData <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    Done <= 1'b0;
                    if (Req) begin
                        we_reg    <= We;
                        addr_reg  <= Addr;
                        wdata_reg <= WData;
                        size_reg  <= Size;
                        Busy      <= 1'b1;
                        Mem_En    <= 1'b1;
                        Mem_Addr  <= {Addr[31:2], 2'b00};
                        if (!We) begin
                            state_reg <= RD;
                            Mem_We    <= 1'b0;
                            Mem_WData <= '0;
                        end else if (Size == 2'b00 || Size == 2'b11) begin
                            state_reg <= WR;
                            Mem_We    <= 1'b1;
                            Mem_WData <= WData;
                        end else begin
                            state_reg <= RMW_RD;
                            Mem_We    <= 1'b0;
                            Mem_WData <= '0;
                        end
                    end
                end
                RD: begin
                    if (Mem_Ready) begin
                        RData     <= Mem_RData;
                        state_reg <= RESP;
                        Done      <= 1'b1;
                        Mem_En    <= 1'b0;
                        Mem_We    <= 1'b0;
                        Mem_Addr  <= '0;
                        Mem_WData <= '0;
                    end else begin
                        Mem_Addr <= {addr_reg[31:2], 2'b00};
                    end
                end
                RMW_RD: begin
                    if (Mem_Ready) begin
                        merge_reg <= merged;
                        state_reg <= RMW_WR;
                        Mem_We    <= we_reg;
                        Mem_WData <= merged;
                    end else begin
                        Mem_Addr <= {addr_reg[31:2], 2'b00};
                    end
                end
                WR, RMW_WR: begin
                    if (Mem_Ready) begin
                        state_reg <= RESP;
                        Done      <= 1'b1;
                        Mem_En    <= 1'b0;
                        Mem_We    <= 1'b0;
                        Mem_Addr  <= '0;
                        Mem_WData <= '0;
                    end else begin
                        Mem_Addr  <= {addr_reg[31:2], 2'b00};
                        Mem_WData <= (state_reg == WR) ? wdata_reg : merge_reg;
                    end
                end
                RESP: begin
                    // Req is deliberately not sampled here; it is re-evaluated from IDLE.
                    state_reg <= IDLE;
                    Done      <= 1'b0;
                    Busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    Done      <= 1'b0;
                    Busy      <= 1'b0;
                    Mem_En    <= 1'b0;
                    Mem_We    <= 1'b0;
                    Mem_Addr  <= '0;
                    Mem_WData <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_rmw_ctrl.sv
// Directed bench for dm_rmw_ctrl. A memory model checks every memory access against a queue
// of expected transactions, and the main sequence checks latency, RData and reset behaviour.
module tb_dm_rmw_ctrl;

    logic        clk;
    logic        reset;
    logic        Req;
    logic        We;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [1:0]  Size;
    logic        Busy;
    logic        Done;
    logic [31:0] RData;
    logic        Mem_En;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic [31:0] Mem_RData;
    logic        Mem_Ready;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } tx_t;

    tx_t         exp_q[$];
    logic [31:0] mem    [0:63];
    logic [31:0] shadow [0:63];
    int          compared;
    int          mismatched;

    dm_rmw_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .Req       (Req),
        .We        (We),
        .Addr      (Addr),
        .WData     (WData),
        .Size      (Size),
        .Busy      (Busy),
        .Done      (Done),
        .RData     (RData),
        .Mem_En    (Mem_En),
        .Mem_We    (Mem_We),
        .Mem_Addr  (Mem_Addr),
        .Mem_WData (Mem_WData),
        .Mem_RData (Mem_RData),
        .Mem_Ready (Mem_Ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign Mem_RData = mem[Mem_Addr[7:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge_model(input logic [31:0] old, input logic [31:0] addr,
                                                input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] mask;
        logic [31:0] data;
        int          sh;
        if (sz == 2'b01) begin
            sh   = addr[1] ? 16 : 0;
            mask = 32'h0000_FFFF << sh;
            data = (wd & 32'h0000_FFFF) << sh;
        end else begin
            sh   = int'(addr[1:0]) * 8;
            mask = 32'h0000_00FF << sh;
            data = (wd & 32'h0000_00FF) << sh;
        end
        return (old & ~mask) | data;
    endfunction

    // Memory model: an access completes on the next rising edge when En and Ready are both high.
    initial begin
        tx_t tx;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        forever begin
            @(negedge clk);
            if (reset && Mem_En && Mem_Ready) begin
                compared++;
                assert (exp_q.size() != 0) else begin
                    mismatched++;
                    $error("FAIL unexpected_access: observed we=%0b addr %h expected none", Mem_We, Mem_Addr);
                end
                if (exp_q.size() != 0) begin
                    tx = exp_q.pop_front();
                    check("acc_we", {31'b0, Mem_We}, {31'b0, tx.we});
                    check("acc_addr", Mem_Addr, tx.addr);
                    if (tx.we) check("acc_wdata", Mem_WData, tx.data);
                end
                if (Mem_We) mem[Mem_Addr[7:2]] = Mem_WData;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    // One request, Req pulsed for a single edge; Mem_Ready held low for 'stall' cycles.
    task automatic run(input logic we_i, input logic [31:0] addr_i, input logic [31:0] wdata_i,
                       input logic [1:0] size_i, input int stall, input int exp_lat, input string tag);
        int cycles;
        bit seen;
        Req = 1'b1; We = we_i; Addr = addr_i; WData = wdata_i; Size = size_i;
        Mem_Ready = (stall == 0);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
            if (cycles == 1) Req = 1'b0;
            if (Done) seen = 1'b1;
            else if (cycles <= stall) begin
                check({tag, "_busy"}, {31'b0, Busy}, 32'd1);
                check({tag, "_en"}, {31'b0, Mem_En}, 32'd1);
                check({tag, "_addr"}, Mem_Addr, {addr_i[31:2], 2'b00});
            end
            if (cycles == stall + 1) Mem_Ready = 1'b1;
        end
        check({tag, "_latency"}, seen ? 32'(cycles) : 32'hFFFF_FFFF, 32'(exp_lat));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'b0, Done}, 32'd0);
        check({tag, "_idle"}, {31'b0, Busy}, 32'd0);
    endtask

    task automatic store_word(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
        tx_t t;
        t.we = 1'b1; t.addr = {addr[31:2], 2'b00}; t.data = data;
        exp_q.push_back(t);
        shadow[addr[7:2]] = data;
        run(1'b1, addr, data, sz, 0, 2, "sw");
        $display("store word addr=%h data=%h size=%0d", addr, data, sz);
    endtask

    task automatic store_part(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
        tx_t         t;
        logic [31:0] nw;
        nw = merge_model(shadow[addr[7:2]], addr, data, sz);
        t.we = 1'b0; t.addr = {addr[31:2], 2'b00}; t.data = 32'h0;
        exp_q.push_back(t);
        t.we = 1'b1; t.data = nw;
        exp_q.push_back(t);
        shadow[addr[7:2]] = nw;
        run(1'b1, addr, data, sz, 0, 3, (sz == 2'b01) ? "sh" : "sb");
        check("part_mem", mem[addr[7:2]], nw);
        $display("store part addr=%h data=%h size=%0d -> word %h", addr, data, sz, nw);
    endtask

    task automatic load(input logic [31:0] addr, input int stall);
        tx_t t;
        t.we = 1'b0; t.addr = {addr[31:2], 2'b00}; t.data = 32'h0;
        exp_q.push_back(t);
        run(1'b0, addr, 32'h0, 2'b00, stall, 2 + stall, "ld");
        check("ld_rdata", RData, shadow[addr[7:2]]);
        $display("load addr=%h stall=%0d rdata=%h", addr, stall, RData);
    endtask

    initial begin
        tx_t t;
        int  cycles;
        bit  seen;
        compared = 0; mismatched = 0;
        for (int i = 0; i < 64; i++) shadow[i] = 32'h0;
        reset = 1'b0; Req = 1'b0; We = 1'b0; Addr = '0; WData = '0; Size = '0; Mem_Ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_done", {31'b0, Done}, 32'd0);
        check("rst_rdata", RData, 32'd0);
        check("rst_mem_en", {31'b0, Mem_En}, 32'd0);
        check("rst_mem_we", {31'b0, Mem_We}, 32'd0);
        check("rst_mem_addr", Mem_Addr, 32'd0);
        check("rst_mem_wdata", Mem_WData, 32'd0);
        $display("reset state checked");
        reset = 1'b1;
        @(posedge clk); #1;

        store_word(32'h10, 32'hDEAD_BEEF, 2'b00);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);
        store_word(32'h20, 32'h1122_3344, 2'b00);
        store_part(32'h22, 32'h0000_00AB, 2'b10);
        check("sb_spec", mem[8], 32'h11AB_3344);
        store_word(32'h20, 32'h1122_3344, 2'b00);
        store_part(32'h23, 32'h0000_CAFE, 2'b01);
        check("sh_spec", mem[8], 32'hCAFE_3344);
        store_part(32'h21, 32'h1234_565A, 2'b10);
        store_part(32'h20, 32'hFFFF_BEEF, 2'b01);
        store_part(32'h13, 32'h0000_0099, 2'b10);
        store_word(32'h3C, 32'hA5A5_0F0F, 2'b11);
        store_word(32'h30, 32'h5566_7788, 2'b00);
        load(32'h30, 3);
        check("ld_stall_rdata", RData, 32'h5566_7788);
        store_word(32'h10, 32'h0, 2'b00);
        check("rdata_after_store", RData, 32'h5566_7788);
        load(32'h20, 0);

        // Reset while the RMW write is waiting for Mem_Ready.
        Req = 1'b1; We = 1'b1; Addr = 32'h20; WData = 32'h77; Size = 2'b10; Mem_Ready = 1'b1;
        t.we = 1'b0; t.addr = 32'h20; t.data = 32'h0;
        exp_q.push_back(t);
        @(posedge clk); #1;
        Req = 1'b0;
        check("rmw_rd_we", {31'b0, Mem_We}, 32'd0);
        @(posedge clk); #1;
        Mem_Ready = 1'b0;
        check("rmw_wr_we", {31'b0, Mem_We}, 32'd1);
        check("rmw_wr_data", Mem_WData, merge_model(shadow[8], 32'h22 - 32'h2, 32'h77, 2'b10));
        #2 reset = 1'b0;
        #1;
        check("abort_busy", {31'b0, Busy}, 32'd0);
        check("abort_mem_en", {31'b0, Mem_En}, 32'd0);
        check("abort_mem_we", {31'b0, Mem_We}, 32'd0);
        check("abort_mem_addr", Mem_Addr, 32'd0);
        check("abort_mem_wdata", Mem_WData, 32'd0);
        check("abort_rdata", RData, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", {31'b0, Done}, 32'd0);
        reset = 1'b1; Mem_Ready = 1'b1;
        @(posedge clk); #1;
        check("abort_done_after", {31'b0, Done}, 32'd0);
        check("abort_mem_kept", mem[8], shadow[8]);
        $display("reset during RMW write checked, word=%h", mem[8]);
        load(32'h20, 0);

        // Req held high across two loads: the second is accepted only from IDLE.
        t.we = 1'b0; t.addr = 32'h30; t.data = 32'h0;
        exp_q.push_back(t);
        exp_q.push_back(t);
        Req = 1'b1; We = 1'b0; Addr = 32'h30; Size = 2'b00; Mem_Ready = 1'b1;
        cycles = 0; seen = 1'b0;
        while (!seen && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
            if (Done) seen = 1'b1;
        end
        check("b2b_first_latency", seen ? 32'(cycles) : 32'hFFFF_FFFF, 32'd2);
        @(posedge clk); #1;
        check("b2b_gap_busy", {31'b0, Busy}, 32'd0);
        check("b2b_gap_en", {31'b0, Mem_En}, 32'd0);
        @(posedge clk); #1;
        Req = 1'b0;
        check("b2b_second_busy", {31'b0, Busy}, 32'd1);
        check("b2b_second_en", {31'b0, Mem_En}, 32'd1);
        cycles = 0; seen = 1'b0;
        while (!seen && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
            if (Done) seen = 1'b1;
        end
        check("b2b_second_latency", seen ? 32'(cycles) : 32'hFFFF_FFFF, 32'd1);
        check("b2b_rdata", RData, 32'h5566_7788);
        $display("back-to-back loads checked, rdata=%h", RData);

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dm_rmw_ctrl.md
DM_RMW_CTRL -- requirements
Module: dm_rmw_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; all state SHALL be clocked on its rising edge.
REQ-002 The block SHALL have reset (input, 1 bit), asynchronous and active-low.
REQ-003 The block SHALL have the following CPU-side ports:
- Req (in, 1): access request.
- We (in, 1): 1 = store, 0 = load.
- Addr (in, 32): byte address.
- WData (in, 32): store data, right-aligned.
- Size (in, 2): 00 word, 01 half, 10 byte, 11 treated as word.
REQ-004 The block SHALL have the following CPU-side response ports:
- Busy (out, 1): high while the controller is not in IDLE.
- Done (out, 1): one-cycle completion pulse.
- RData (out, 32): full word returned by the last load.
REQ-005 The block SHALL have the following memory-side ports. The memory is a word-only port with no byte enables.
- Mem_En (out, 1)
- Mem_We (out, 1)
- Mem_Addr (out, 32)
- Mem_WData (out, 32)
- Mem_RData (in, 32)
- Mem_Ready (in, 1): the access completes on the rising edge where Mem_En and Mem_Ready are both high.

Function
REQ-006 The block SHALL implement a state machine with states IDLE, RD, RMW_RD, RMW_WR, WR and RESP.
REQ-007 In IDLE with Req=1, the block SHALL latch We, Addr, WData and Size into internal registers and transition as follows:
- We=0 -> RD.
- We=1 with Size 00 or 11 -> WR.
- We=1 with Size 01 or 10 -> RMW_RD.
REQ-008 In IDLE with Req=0, the block SHALL remain in IDLE. CPU inputs SHALL be ignored in every state other than IDLE.
REQ-009 In RD and RMW_RD, the block SHALL drive Mem_En=1 and Mem_We=0.
REQ-010 In WR and RMW_WR, the block SHALL drive Mem_En=1 and Mem_We=1.
REQ-011 In IDLE and RESP, the block SHALL drive Mem_En=0 and Mem_We=0.
REQ-012 Mem_Addr SHALL equal {latched Addr[31:2], 2'b00} in every access state and 0 otherwise.
REQ-013 The block SHALL hold each access state, with all memory outputs stable, until Mem_Ready=1 is sampled.
REQ-014 On completion of RD, the block SHALL load Mem_RData into RData and go to RESP.
REQ-015 On completion of RMW_RD, the block SHALL load the merged word into a merge register and go to RMW_WR.
REQ-016 On completion of WR or RMW_WR, the block SHALL go to RESP.
REQ-017 Merge rules, using the latched Addr[1:0] and Size:
- Size 01 with Addr[1]=0: replace bits [15:0] of Mem_RData with WData[15:0].
- Size 01 with Addr[1]=1: replace bits [31:16] of Mem_RData with WData[15:0].
- Size 10: replace byte lane Addr[1:0] of Mem_RData with WData[7:0].
- All other bits SHALL pass through unchanged.
REQ-018 For Size 01, the block SHALL ignore Addr[0]; misaligned accesses SHALL NOT be detected.
REQ-019 Mem_WData SHALL be driven as follows:
- In WR: latched WData.
- In RMW_WR: the merge register.
- Otherwise: 0.
REQ-020 In RESP, the block SHALL assert Done=1 for exactly one cycle and go to IDLE. A Req present during RESP SHALL NOT be accepted.
REQ-021 Busy SHALL be 1 in every state except IDLE. Done SHALL be 0 outside RESP.
REQ-022 RData SHALL change only on RD completion and SHALL be unaffected by stores.
REQ-023 Minimum latency from Req acceptance edge to Done high, with Mem_Ready tied to 1:
- Load or word store: 2 cycles.
- Partial store: 3 cycles.
Each cycle of Mem_Ready=0 SHALL add one cycle.

Reset
REQ-024 While reset=0, the block SHALL immediately force state=IDLE and Busy=0, Done=0, RData=0, Mem_En=0, Mem_We=0, Mem_Addr=0, Mem_WData=0, and clear the merge register and all latched request registers to 0.
REQ-025 Reset asserted mid-access (including between RMW_RD and RMW_WR) SHALL abandon the access without issuing any memory write, and SHALL NOT produce Done.
REQ-026 After reset deasserts, the first rising edge SHALL evaluate IDLE normally.

Verification
REQ-027 Word store: Addr=0x0000_0010, WData=0xDEAD_BEEF, Size=00, Mem_Ready=1 -> exactly one write to 0x10 with data 0xDEADBEEF, no read, and Done 2 cycles after acceptance.
REQ-028 Byte store: memory word at 0x20 = 0x1122_3344; sb Addr=0x22, WData=0xAB -> one read of 0x20, then one write of 0x11AB_3344, Done 3 cycles after acceptance.
REQ-029 Half store: memory word at 0x20 = 0x1122_3344; sh Addr=0x23, WData=0xCAFE -> write data 0xCAFE_3344 (Addr[0] ignored).
REQ-030 Load with Mem_Ready held low for 3 cycles, memory data 0x5566_7788 -> Busy=1 throughout, Mem_En and Mem_Addr stable, RData=0x55667788, Done 5 cycles after acceptance.
REQ-031 Reset=0 asserted in RMW_WR before Mem_Ready -> all outputs 0 immediately, the memory word is unchanged, and no Done is produced; the next Req is serviced normally.
REQ-032 Req held high continuously across two back-to-back loads -> the second request is accepted only in IDLE, following the first request's RESP, with no overlap of accesses.
